regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the CPU general-purpose register file.
- Configurable data width, depth and number of combinational read ports; register 0 can be made hard-wired zero.
- Adds a post-reset hardware clear sweep with a busy flag.
- Adds a per-register pending scoreboard so the pipeline control can detect read-after-write hazards.
- Sits between decode (read/reserve) and writeback (write) in the CPU datapath.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W entries.
- NREAD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, when 1, entry 0 always reads 0 and ignores writes and reserves.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  synchronous active-low reset, sampled on the rising edge of CLK.
- RegWrite  input  1  write enable (writeback stage).
- wrreg  input  ADDR_W  write index.
- wrdata  input  DATA_W  write data.
- Reserve  input  1  mark rsv_reg as pending (decode issues an instruction that will write it).
- rsv_reg  input  ADDR_W  reserve index.
- rd_addr  input  NREAD*ADDR_W  packed read indices; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  output  NREAD*DATA_W  packed read data, combinational.
- rd_pend  output  NREAD  pending bit of the register addressed by each read port, combinational.
- Busy  output  1  high while the clear sweep runs.

Behaviour:
- Storage: DEPTH x DATA_W array plus a DEPTH-bit pending vector.
- FSM states: CLEAR, IDLE.
- Reset:
  - A rising edge with RST_N=0 sets state=CLEAR, clear pointer ptr=0 and all pending bits to 0.
  - While RST_N stays low, state stays CLEAR with ptr=0; no array writes.
- CLEAR (RST_N=1):
  - Each edge writes 0 to mem[ptr] and increments ptr.
  - The edge that clears entry DEPTH-1 moves the state to IDLE.
  - Busy is therefore 1 for exactly DEPTH cycles after RST_N deasserts; Busy=1 throughout reset.
- During CLEAR:
  - RegWrite and Reserve are ignored.
  - rd_data is forced to 0 and rd_pend to 0 on all ports.
- IDLE write:
  - On an edge with RegWrite=1, mem[wrreg]<=wrdata and pending[wrreg]<=0.
  - Skipped entirely when ZERO_REG=1 and wrreg=0.
- IDLE reserve:
  - On an edge with Reserve=1, pending[rsv_reg]<=1.
  - Ignored when ZERO_REG=1 and rsv_reg=0.
- Same edge, same index, write and reserve: the data write occurs and pending ends at 1 (new producer wins).
- Same edge, different indices: both take effect.
- Reads (IDLE):
  - rd_data port k = mem[rd_addr k]; rd_pend port k = pending[rd_addr k].
  - With ZERO_REG=1 and index 0: data 0, pend 0.
  - Ports are fully independent; the same index on several ports is legal.
- Read-during-write default: a read returns the old value until the edge; the new value is visible the cycle after.
- Reset mid-sweep: ptr restarts at 0 and the full DEPTH-cycle sweep reruns.
- Reset (RST_N=0) outputs: Busy=1, rd_data=0, rd_pend=0.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined:
  - Any read port whose index equals wrreg while RegWrite=1 (state IDLE, not the zero register) returns wrdata combinationally.
  - That port's rd_pend reads 0, unless Reserve targets the same index in the same cycle, in which case rd_pend reads 1.
- Undefined:
  - No forwarding; reads see the array contents and the pending bit as of the last edge.

Test Plan:
- Reset and sweep: pulse RST_N low 2 cycles with DEPTH=32 -> Busy high 32 cycles after release, then 0; all 32 entries read 0, all rd_pend 0.
- Basic write: write 0xDEADBEEF to r5, read r5 on ports 0 and 1 the next cycle -> both 0xDEADBEEF; same-cycle read returns the old value (0) without BYPASS and 0xDEADBEEF with BYPASS.
- Zero register: ZERO_REG=1, write 0x12345678 to r0 and Reserve r0 -> r0 reads 0, rd_pend 0.
- Scoreboard: Reserve r7 -> rd_pend=1 next cycle; write r7=0x55 -> rd_pend=0 and data 0x55 next cycle; same-edge Reserve r7 plus write r7=0x66 -> data 0x66, rd_pend stays 1.
- Clear interactions: RegWrite r3=0xAA during the sweep -> ignored, r3 reads 0 after Busy falls; assert RST_N low at sweep cycle 10 -> Busy persists, a fresh 32-cycle sweep runs after release.
- Parametrisation: DATA_W=16, ADDR_W=3, NREAD=4; write distinct values to r1..r7, read all four ports at different indices simultaneously -> each port returns its own value; Busy lasts 8 cycles after reset.

Source files
------------

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with post-reset clear sweep and pending scoreboard.
// Optional same-cycle write forwarding on the read ports: define REGFILE_MP_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      RegWrite,
  input  logic [ADDR_W-1:0]         wrreg,
  input  logic [DATA_W-1:0]         wrdata,
  input  logic                      Reserve,
  input  logic [ADDR_W-1:0]         rsv_reg,
  input  logic [NREAD*ADDR_W-1:0]   rd_addr,
  output logic [NREAD*DATA_W-1:0]   rd_data,
  output logic [NREAD-1:0]          rd_pend,
  output logic                      Busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  state_t              state_r, state_nxt_s;
  logic [ADDR_W-1:0]   ptr_r, ptr_nxt_s;
  logic [DEPTH-1:0]    pend_r, pend_nxt_s;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_wa_s;
  logic [DATA_W-1:0]   mem_wd_s;
  logic                wr_ok_s, rsv_ok_s;
  logic [ADDR_W-1:0]   ra_s [NREAD];

  for (genvar g = 0; g < NREAD; g++) begin : g_ra
    assign ra_s[g] = rd_addr[g*ADDR_W +: ADDR_W];
  end

  // Write/reserve qualification: the hard-wired zero entry swallows both.
  always_comb begin
    wr_ok_s  = RegWrite;
    rsv_ok_s = Reserve;
    if ((ZERO_REG != 0) && (wrreg == {ADDR_W{1'b0}})) begin
      wr_ok_s = 1'b0;
    end else begin
      wr_ok_s = RegWrite;
    end
    if ((ZERO_REG != 0) && (rsv_reg == {ADDR_W{1'b0}})) begin
      rsv_ok_s = 1'b0;
    end else begin
      rsv_ok_s = Reserve;
    end
  end

  // Next-state logic: clear sweep, then writeback and scoreboard updates.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    pend_nxt_s  = pend_r;
    mem_we_s    = 1'b0;
    mem_wa_s    = ptr_r;
    mem_wd_s    = {DATA_W{1'b0}};
    case (state_r)
      CLEAR: begin
        mem_we_s  = RST_N;
        ptr_nxt_s = ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (ptr_r == {ADDR_W{1'b1}}) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      IDLE: begin
        if (wr_ok_s) begin
          mem_we_s          = RST_N;
          mem_wa_s          = wrreg;
          mem_wd_s          = wrdata;
          pend_nxt_s[wrreg] = 1'b0;
        end else begin
          mem_we_s = 1'b0;
        end
        // Reserve applied after the write so a new producer wins on the same index.
        if (rsv_ok_s) begin
          pend_nxt_s[rsv_reg] = 1'b1;
        end else begin
          pend_nxt_s[rsv_reg] = pend_nxt_s[rsv_reg];
        end
      end
      default: begin
        state_nxt_s = CLEAR;
        ptr_nxt_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= CLEAR;
      ptr_r   <= {ADDR_W{1'b0}};
      pend_r  <= {DEPTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      pend_r  <= pend_nxt_s;
    end
  end

  // Storage array; contents are initialised by the sweep, not by reset.
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem_r[mem_wa_s] <= mem_wd_s;
    end
  end

  // Read ports: zeroed during reset/sweep and for the hard-wired zero entry.
  always_comb begin
    rd_data = {(NREAD*DATA_W){1'b0}};
    rd_pend = {NREAD{1'b0}};
    for (int k = 0; k < NREAD; k++) begin
      if (RST_N && (state_r == IDLE) &&
          !((ZERO_REG != 0) && (ra_s[k] == {ADDR_W{1'b0}}))) begin
        rd_data[k*DATA_W +: DATA_W] = mem_r[ra_s[k]];
        rd_pend[k]                  = pend_r[ra_s[k]];
`ifdef REGFILE_MP_BYPASS_EN
        if (RegWrite && (wrreg == ra_s[k])) begin
          rd_data[k*DATA_W +: DATA_W] = wrdata;
          rd_pend[k]                  = Reserve && (rsv_reg == ra_s[k]);
        end else begin
          rd_pend[k] = pend_r[ra_s[k]];
        end
`endif
      end else begin
        rd_data[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        rd_pend[k]                  = 1'b0;
      end
    end
  end

  // Busy covers both the reset itself and the sweep that follows it.
  always_comb begin
    if (!RST_N) begin
      Busy = 1'b1;
    end else begin
      Busy = (state_r == CLEAR);
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: default 32x32/2-port instance and a 8x16/4-port instance.
module tb_regfile_mp;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instance A: default parameters
  logic        rst_n_a, we_a, rsv_a, busy_a;
  logic [4:0]  wrreg_a, rsvreg_a;
  logic [31:0] wrdata_a;
  logic [9:0]  rdaddr_a;
  logic [63:0] rddata_a;
  logic [1:0]  rdpend_a;

  // Instance B: DATA_W=16, ADDR_W=3, NREAD=4
  logic        rst_n_b, we_b, rsv_b, busy_b;
  logic [2:0]  wrreg_b, rsvreg_b;
  logic [15:0] wrdata_b;
  logic [11:0] rdaddr_b;
  logic [63:0] rddata_b;
  logic [3:0]  rdpend_b;

  regfile_mp u_a (
    .CLK(CLK), .RST_N(rst_n_a), .RegWrite(we_a), .wrreg(wrreg_a), .wrdata(wrdata_a),
    .Reserve(rsv_a), .rsv_reg(rsvreg_a), .rd_addr(rdaddr_a), .rd_data(rddata_a),
    .rd_pend(rdpend_a), .Busy(busy_a)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NREAD(4), .ZERO_REG(1)) u_b (
    .CLK(CLK), .RST_N(rst_n_b), .RegWrite(we_b), .wrreg(wrreg_b), .wrdata(wrdata_b),
    .Reserve(rsv_b), .rsv_reg(rsvreg_b), .rd_addr(rdaddr_b), .rd_data(rddata_b),
    .rd_pend(rdpend_b), .Busy(busy_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic rd_a(input logic [4:0] p0, input logic [4:0] p1);
    rdaddr_a = {p1, p0};
    #1;
  endtask

  // Counts cycles with Busy high on instance A, starting just after reset release.
  task automatic count_busy_a(output int cnt);
    cnt = 0;
    while (busy_a && cnt < 100) begin
      cnt++;
      tick();
    end
  endtask

  logic [15:0] exp_b [4];
  int          cnt;

  initial begin
    rst_n_a = 1'b0; we_a = 1'b0; rsv_a = 1'b0; wrreg_a = 5'd0; rsvreg_a = 5'd0;
    wrdata_a = 32'd0; rdaddr_a = 10'd0;
    rst_n_b = 1'b0; we_b = 1'b0; rsv_b = 1'b0; wrreg_b = 3'd0; rsvreg_b = 3'd0;
    wrdata_b = 16'd0; rdaddr_b = 12'd0;

    // Reset held two cycles
    tick(); tick();
    rd_a(5'd5, 5'd9);
    chk("rst_busy", {63'd0, busy_a}, 64'd1);
    chk("rst_rd_data", rddata_a, 64'd0);
    chk("rst_rd_pend", {62'd0, rdpend_a}, 64'd0);

    // Release; try a write to r3 during the sweep
    rst_n_a = 1'b1;
    cnt = 0;
    while (busy_a && cnt < 100) begin
      cnt++;
      if (cnt == 5) begin
        we_a = 1'b1; wrreg_a = 5'd3; wrdata_a = 32'h0000_00AA;
        rd_a(5'd3, 5'd3);
        chk("sweep_rd_data", rddata_a, 64'd0);
      end else begin
        we_a = 1'b0;
      end
      tick();
    end
    we_a = 1'b0;
    chk("sweep_len", cnt, 64'd32);
    chk("idle_busy", {63'd0, busy_a}, 64'd0);

    // All entries cleared, no pending
    for (int i = 0; i < 32; i++) begin
      rd_a(i[4:0], 5'(31 - i));
      chk("clr_data", rddata_a, 64'd0);
      chk("clr_pend", {62'd0, rdpend_a}, 64'd0);
    end

    // Basic write r5, same-cycle and next-cycle read
    we_a = 1'b1; wrreg_a = 5'd5; wrdata_a = 32'hDEADBEEF;
    rd_a(5'd5, 5'd5);
`ifdef REGFILE_MP_BYPASS_EN
    chk("wr_same_cycle", rddata_a, 64'hDEADBEEF_DEADBEEF);
`else
    chk("wr_same_cycle", rddata_a, 64'd0);
`endif
    tick();
    we_a = 1'b0;
    rd_a(5'd5, 5'd5);
    chk("wr_next_cycle", rddata_a, 64'hDEADBEEF_DEADBEEF);

    // Zero register ignores write and reserve
    we_a = 1'b1; wrreg_a = 5'd0; wrdata_a = 32'h12345678; rsv_a = 1'b1; rsvreg_a = 5'd0;
    tick();
    we_a = 1'b0; rsv_a = 1'b0;
    rd_a(5'd0, 5'd5);
    chk("zero_data", rddata_a, {32'hDEADBEEF, 32'd0});
    chk("zero_pend", {62'd0, rdpend_a}, 64'd0);

    // Scoreboard on r7
    rsv_a = 1'b1; rsvreg_a = 5'd7;
    tick();
    rsv_a = 1'b0;
    rd_a(5'd7, 5'd0);
    chk("rsv_pend", {62'd0, rdpend_a}, 64'd1);
    we_a = 1'b1; wrreg_a = 5'd7; wrdata_a = 32'h55;
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    chk("wr7_same_pend", {62'd0, rdpend_a}, 64'd0);
`else
    chk("wr7_same_pend", {62'd0, rdpend_a}, 64'd1);
`endif
    tick();
    we_a = 1'b0;
    #1;
    chk("wr7_data", rddata_a, 64'h55);
    chk("wr7_pend", {62'd0, rdpend_a}, 64'd0);
    we_a = 1'b1; wrdata_a = 32'h66; rsv_a = 1'b1; rsvreg_a = 5'd7;
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    chk("wr_rsv_same_data", rddata_a, 64'h66);
    chk("wr_rsv_same_pend", {62'd0, rdpend_a}, 64'd1);
`else
    chk("wr_rsv_same_data", rddata_a, 64'h55);
    chk("wr_rsv_same_pend", {62'd0, rdpend_a}, 64'd0);
`endif
    tick();
    we_a = 1'b0; rsv_a = 1'b0;
    #1;
    chk("wr_rsv_data", rddata_a, 64'h66);
    chk("wr_rsv_pend", {62'd0, rdpend_a}, 64'd1);

    // Write and reserve to different indices on the same edge
    we_a = 1'b1; wrreg_a = 5'd8; wrdata_a = 32'h11; rsv_a = 1'b1; rsvreg_a = 5'd9;
    tick();
    we_a = 1'b0; rsv_a = 1'b0;
    rd_a(5'd8, 5'd9);
    chk("diff_data8", rddata_a[31:0], 64'h11);
    chk("diff_pend", {62'd0, rdpend_a}, 64'b10);

    // Reset mid-sweep
    rst_n_a = 1'b0;
    tick();
    rd_a(5'd5, 5'd7);
    chk("rst2_busy", {63'd0, busy_a}, 64'd1);
    chk("rst2_rd_data", rddata_a, 64'd0);
    rst_n_a = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy", {63'd0, busy_a}, 64'd1);
    rst_n_a = 1'b0;
    tick();
    chk("mid_rst_busy", {63'd0, busy_a}, 64'd1);
    rst_n_a = 1'b1;
    count_busy_a(cnt);
    chk("resweep_len", cnt, 64'd32);
    rd_a(5'd5, 5'd7);
    chk("resweep_data", rddata_a, 64'd0);
    chk("resweep_pend", {62'd0, rdpend_a}, 64'd0);

    // Instance B: 8 entries, 4 ports
    tick();
    rst_n_b = 1'b1;
    cnt = 0;
    while (busy_b && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("b_sweep_len", cnt, 64'd8);
    for (int i = 1; i < 8; i++) begin
      we_b = 1'b1; wrreg_b = i[2:0]; wrdata_b = 16'(i * 16'h1111);
      tick();
    end
    we_b = 1'b0;
    rdaddr_b = {3'd7, 3'd5, 3'd3, 3'd1};
    exp_b[0] = 16'h1111; exp_b[1] = 16'h3333; exp_b[2] = 16'h5555; exp_b[3] = 16'h7777;
    #1;
    for (int k = 0; k < 4; k++) chk("b_port_a", rddata_b[k*16 +: 16], exp_b[k]);
    rdaddr_b = {3'd0, 3'd2, 3'd6, 3'd7};
    exp_b[0] = 16'h7777; exp_b[1] = 16'h6666; exp_b[2] = 16'h2222; exp_b[3] = 16'h0000;
    #1;
    for (int k = 0; k < 4; k++) chk("b_port_b", rddata_b[k*16 +: 16], exp_b[k]);
    chk("b_pend", {60'd0, rdpend_b}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
